// File: rtl/if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// if_prefetch_queue
//   Instruction-fetch front end. Issues in-order word fetches to a
//   variable-latency instruction memory, buffers the returned words together
//   with their PC in a DEPTH-entry FIFO and presents the head entry to the
//   IF/ID register. Handles IF stall and branch redirect; responses that were
//   already in flight when a redirect happens are counted and thrown away.
//
// Ports
//   clk_i            clock, rising edge
//   clr_n_i          asynchronous active-low reset
//   en_i             global enable (0 freezes issue/pop/redirect/FSM; responses still land)
//   stall_i          IF/ID hold, head is not consumed
//   redirect_i       branch/jump taken: flush and refetch from redirect_addr_i
//   redirect_addr_i  new fetch PC (word aligned)
//   mem_req_valid_o  request valid          mem_req_addr_o   request word address
//   mem_req_ready_i  memory accepts request
//   mem_rsp_valid_i  response valid (in order, one per accepted request)
//   mem_rsp_data_i   response instruction word
//   inst_valid_o     head entry valid       inst_o           head instruction
//   inst_pc_o        PC of head             inst_pc_add4_o   inst_pc_o + 4
//   count_o          FIFO occupancy         proto_err_o      sticky: response with nothing outstanding
// ----------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_OUT    = 2,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic                     clk_i,
    input  logic                     clr_n_i,
    input  logic                     en_i,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_addr_i,
    output logic                     mem_req_valid_o,
    output logic [31:0]              mem_req_addr_o,
    input  logic                     mem_req_ready_i,
    input  logic                     mem_rsp_valid_i,
    input  logic [31:0]              mem_rsp_data_i,
    output logic                     inst_valid_o,
    output logic [31:0]              inst_o,
    output logic [31:0]              inst_pc_o,
    output logic [31:0]              inst_pc_add4_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     proto_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    // PC belonging to the next response that will actually be kept
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic            proto_err_q, proto_err_d;

    logic [31:0]     data_mem [DEPTH];
    logic [31:0]     pc_mem   [DEPTH];

    logic            run;
    logic            redir;
    logic            rsp_ok;
    logic            issue;
    logic            push;
    logic            pop;
    logic            drop_hit;
    logic [CW:0]     reserved;

    always_comb begin
        run      = (state_q == ST_RUN);
        // Redirect is only meaningful once fetching has started and EN is high
        redir    = en_i & redirect_i & (state_q != ST_IDLE);
        rsp_ok   = mem_rsp_valid_i & (outst_q != '0);
        // Words already buffered plus words still coming must fit the FIFO,
        // which is what makes an overflow on push impossible.
        reserved = {1'b0, count_q} + {1'b0, outst_q};

        mem_req_valid_o = run & en_i & ~redirect_i
                        & (outst_q < CW'(MAX_OUT))
                        & (reserved < (CW+1)'(DEPTH));
        issue    = mem_req_valid_o & mem_req_ready_i;
        drop_hit = rsp_ok & (drop_q != '0);
        push     = rsp_ok & (drop_q == '0) & ~redir;
        inst_valid_o = (count_q != '0) & run;
        pop      = inst_valid_o & en_i & ~stall_i & ~redir;

        outst_d     = outst_q + CW'(issue) - CW'(rsp_ok);
        proto_err_d = proto_err_q | (mem_rsp_valid_i & (outst_q == '0));

        if (redir) begin
            // Everything still outstanding (minus a response landing now) is stale
            drop_d     = outst_q - CW'(rsp_ok);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redirect_addr_i;
            rsp_pc_d   = redirect_addr_i;
        end else begin
            drop_d     = drop_q - CW'(drop_hit);
            count_d    = count_q + CW'(push) - CW'(pop);
            wr_ptr_d   = wr_ptr_q + AW'(push);
            rd_ptr_d   = rd_ptr_q + AW'(pop);
            fetch_pc_d = issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
            rsp_pc_d   = push  ? rsp_pc_q + 32'd4   : rsp_pc_q;
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en_i) state_d = ST_RUN;
            ST_RUN:   if (redir && drop_d != '0) state_d = ST_DRAIN;
            ST_DRAIN: if (!redir && en_i && drop_d == '0) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_ADDR;
            rsp_pc_q    <= RESET_ADDR;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            outst_q     <= '0;
            drop_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted valid
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= mem_rsp_data_i;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    assign mem_req_addr_o = fetch_pc_q;
    assign inst_o         = inst_valid_o ? data_mem[rd_ptr_q] : 32'h0;
    assign inst_pc_o      = inst_valid_o ? pc_mem[rd_ptr_q]   : 32'h0;
    assign inst_pc_add4_o = inst_pc_o + 32'd4;
    assign count_o        = count_q;
    assign proto_err_o    = proto_err_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_prefetch_queue
//   Scoreboard bench: each accepted fetch pushes its expected {pc, word} onto
//   a queue; each consumed head entry is popped and compared. A small memory
//   model returns words in order after a programmable latency.
// ----------------------------------------------------------------------------
module tb_if_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        clr_n_i = 1'b0;
    logic        en_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = 32'h0;
    logic        mem_req_valid_o;
    logic [31:0] mem_req_addr_o;
    logic        mem_req_ready_i = 1'b0;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_data_i = 32'h0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_pc_add4_o;
    logic [$clog2(DEPTH):0] count_o;
    logic        proto_err_o;

    if_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUT(2), .RESET_ADDR(32'h0)) dut (
        .clk_i(clk_i), .clr_n_i(clr_n_i), .en_i(en_i), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_ready_i(mem_req_ready_i), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_data_i(mem_rsp_data_i), .inst_valid_o(inst_valid_o),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_pc_add4_o(inst_pc_add4_o),
        .count_o(count_o), .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    req_t        pending[$];
    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    int          npops = 0;
    int          first_valid_cyc = -1;
    logic [31:0] exp_fetch = 32'h0;
    bit          post_redir_chk = 0;
    bit          hold_chk = 0;
    bit          first_pop_seen = 0;
    logic [31:0] first_pop_pc = 32'h0;
    bit          first_req_seen = 0;
    logic [31:0] first_req_addr = 32'h0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // One clock: drive inputs at the falling edge, observe #1 later,
    // update the scoreboard for the handshakes at the next rising edge.
    task automatic step(input bit st, input bit rd, input logic [31:0] ra,
                        input bit rdy, input bit inject);
        cyc++;
        stall_i         = st;
        redirect_i      = rd;
        redirect_addr_i = ra;
        mem_req_ready_i = rdy;
        if (inject) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = 32'hDEAD_BEEF;
        end else if (pending.size() > 0 && pending[0].due <= cyc) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = mdata(pending[0].addr);
            void'(pending.pop_front());
        end else begin
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = 32'h0;
        end
        #1;
        if (post_redir_chk) begin
            chk("flush_inst_valid", {31'h0, inst_valid_o}, 32'h0);
            chk("flush_count", 32'(count_o), 32'h0);
            post_redir_chk = 0;
        end
        if (hold_chk) begin
            chk("hold_req_valid", {31'h0, mem_req_valid_o}, 32'h1);
            chk("hold_req_addr", mem_req_addr_o, exp_fetch);
        end
        if (inst_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (inst_valid_o && !st && !rd) begin
            if (exp_q.size() == 0) begin
                chk("extra_inst", {31'h0, inst_valid_o}, 32'h0);
            end else begin
                chk("inst_pc", inst_pc_o, exp_q[0].pc);
                chk("inst", inst_o, exp_q[0].data);
                chk("inst_pc_add4", inst_pc_add4_o, exp_q[0].pc + 32'd4);
                $display("pop  cyc=%0d pc=%h inst=%h", cyc, inst_pc_o, inst_o);
                if (!first_pop_seen) begin
                    first_pop_seen = 1;
                    first_pop_pc   = inst_pc_o;
                end
                void'(exp_q.pop_front());
                npops++;
            end
        end
        if (rd) begin
            chk("req_during_redirect", {31'h0, mem_req_valid_o}, 32'h0);
            exp_q.delete();
            exp_fetch      = ra;
            post_redir_chk = 1;
            first_pop_seen = 0;
            first_req_seen = 0;
            $display("redirect cyc=%0d to %h", cyc, ra);
        end else if (mem_req_valid_o && rdy) begin
            chk("req_addr", mem_req_addr_o, exp_fetch);
            if (!first_req_seen) begin
                first_req_seen = 1;
                first_req_addr = mem_req_addr_o;
            end
            exp_q.push_back('{pc: exp_fetch, data: mdata(exp_fetch)});
            pending.push_back('{addr: mem_req_addr_o, due: cyc + lat});
            exp_fetch = exp_fetch + 32'd4;
        end
        @(negedge clk_i);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 1, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (pending.size() > 0 || exp_q.size() > 0); i++)
            step(0, 0, 32'h0, 0, 0);
        chk("drain_left", exp_q.size(), 32'h0);
        chk("drain_count", 32'(count_o), 32'h0);
    endtask

    task automatic do_reset();
        clr_n_i = 1'b0;
        stall_i = 0; redirect_i = 0; mem_req_ready_i = 0;
        mem_rsp_valid_i = 0; mem_rsp_data_i = 32'h0;
        #1;
        chk("rst_req_valid", {31'h0, mem_req_valid_o}, 32'h0);
        chk("rst_req_addr", mem_req_addr_o, 32'h0);
        chk("rst_inst_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_inst_pc", inst_pc_o, 32'h0);
        chk("rst_count", 32'(count_o), 32'h0);
        chk("rst_proto_err", {31'h0, proto_err_o}, 32'h0);
        exp_q.delete();
        pending.delete();
        exp_fetch = 32'h0;
        post_redir_chk = 0;
        first_valid_cyc = -1;
        repeat (2) @(negedge clk_i);
        clr_n_i = 1'b1;
        cyc = 0;
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk_i);
        do_reset();

        // T1: zero-wait memory, latency and throughput
        lat = 1;
        npops = 0;
        run(12);
        chk("t1_latency", 32'(first_valid_cyc), 32'd3);
        chk("t1_pops", 32'(npops), 32'd10);

        // T2: stall fills the FIFO and stops issue
        for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 1, 0);
        chk("t2_count_full", 32'(count_o), 32'd4);
        chk("t2_req_blocked", {31'h0, mem_req_valid_o}, 32'h0);
        run(10);

        // T3: two in flight, redirect; late words must be dropped
        lat = 4;
        for (int i = 0; i < 20 && pending.size() != 2; i++) run(1);
        step(0, 1, 32'h40, 1, 0);
        run(20);
        chk("t3_pop_seen", {31'h0, first_pop_seen}, 32'h1);
        chk("t3_first_pc", first_pop_pc, 32'h40);

        // T4: redirect coinciding with a response and a pop
        lat = 1;
        run(8);
        step(0, 1, 32'h100, 1, 0);
        run(10);
        chk("t4_first_req", first_req_addr, 32'h100);
        chk("t4_first_pc", first_pop_pc, 32'h100);

        // T5: memory not ready; address must hold
        hold_chk = 1;
        for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0, 0);
        hold_chk = 0;
        run(10);

        // T6: protocol error, then reset mid-stream
        drain();
        chk("t6_proto_before", {31'h0, proto_err_o}, 32'h0);
        step(0, 0, 32'h0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 0, 0);
            chk("t6_proto_sticky", {31'h0, proto_err_o}, 32'h1);
        end
        run(5);
        do_reset();
        run(8);
        drain();
        chk("t6_proto_after", {31'h0, proto_err_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
